// File: rtl/avalon_pkg.sv
// Shared definitions for the Avalon-MM memory responder.
// Contents: FSM state encoding, bus widths, burst limits and the
// burstcount clamp helper used on command acceptance.
package avalon_pkg;

    localparam int unsigned AVL_DATA_W    = 32;
    localparam int unsigned AVL_BE_W      = 4;
    localparam int unsigned AVL_BCNT_W    = 3;
    localparam int unsigned AVL_MAX_BURST = 4;

    typedef enum logic [2:0] {
        IDLE,
        CMD_WAIT,
        WRITE,
        READ_LAT,
        READ_DATA
    } avl_state_e;

    // Clamped burst length plus an illegal-request flag
    typedef struct packed {
        logic [AVL_BCNT_W-1:0] beats;
        logic                  err;
    } avl_burst_t;

    // Map burstcount to a legal beat count: 0 -> 1, above max -> max
    function automatic avl_burst_t clamp_burst(input logic [AVL_BCNT_W-1:0] bc);
        avl_burst_t r;
        r.beats = bc;
        r.err   = 1'b0;
        if (bc == AVL_BCNT_W'(0)) begin
            r.beats = AVL_BCNT_W'(1);
            r.err   = 1'b1;
        end else if (bc > AVL_BCNT_W'(AVL_MAX_BURST)) begin
            r.beats = AVL_BCNT_W'(AVL_MAX_BURST);
            r.err   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/avalon_resp_ram.sv
// Single-port dword RAM with byte-enable writes and a synchronous
// one-cycle read. Only the read data register is reset; contents are not.
// Ports: clk, rst (sync, active-high), i_addr, i_we, i_be, i_wdata,
//        i_re, o_rdata (registered read data).
module avalon_resp_ram
    import avalon_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic                  i_we,
    input  logic [AVL_BE_W-1:0]   i_be,
    input  logic [AVL_DATA_W-1:0] i_wdata,
    input  logic                  i_re,
    output logic [AVL_DATA_W-1:0] o_rdata
);

    logic [AVL_DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [AVL_DATA_W-1:0] r_rdata;

    // Byte-lane writes; storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            if (i_be[0]) r_mem[i_addr][7:0]   <= i_wdata[7:0];
            if (i_be[1]) r_mem[i_addr][15:8]  <= i_wdata[15:8];
            if (i_be[2]) r_mem[i_addr][23:16] <= i_wdata[23:16];
            if (i_be[3]) r_mem[i_addr][31:24] <= i_wdata[31:24];
        end
    end

    // Read data holds its value between read enables
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM burst slave terminating the CPU memory master: byte-enabled
// write bursts and read bursts (1-4 dwords) into an internal dword RAM,
// with configurable command wait-states and read latency.
// Ports: clk, rst (sync, active-high); avs_address/writedata/byteenable/
//        burstcount/write/read (master requests); avs_waitrequest (comb),
//        avs_readdatavalid/avs_readdata/protocol_error (registered).
module avalon_mem_responder
    import avalon_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned WAIT_CYCLES  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             avs_address,
    input  logic [AVL_DATA_W-1:0]   avs_writedata,
    input  logic [AVL_BE_W-1:0]     avs_byteenable,
    input  logic [AVL_BCNT_W-1:0]   avs_burstcount,
    input  logic                    avs_write,
    input  logic                    avs_read,
    output logic                    avs_waitrequest,
    output logic                    avs_readdatavalid,
    output logic [AVL_DATA_W-1:0]   avs_readdata,
    output logic                    protocol_error
);

    localparam int unsigned ADDR_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_LAST  = 4'(READ_LATENCY - 1);
    localparam logic [2:0]  WAIT_LAST = 3'(WAIT_CYCLES);

    avl_state_e                r_state;
    logic [ADDR_W-1:0]         r_base;
    logic [AVL_BCNT_W-1:0]     r_beats;
    logic [AVL_BCNT_W-1:0]     r_beat;
    logic [2:0]                r_wait_cnt;
    logic [3:0]                r_lat;
    logic                      r_rdvalid;
    logic                      r_perr;

    logic [ADDR_W-1:0]         w_bus_idx;
    avl_burst_t                w_burst;
    logic                      w_req;
    logic                      w_wait;
    logic                      w_accept;
    logic                      w_acc_wr;
    logic                      w_acc_rd;
    logic                      w_last_beat;
    logic                      w_ram_we;
    logic                      w_ram_re;
    logic [ADDR_W-1:0]         w_ram_addr;
    logic [AVL_DATA_W-1:0]     w_ram_rdata;
    logic                      w_unused_addr;

    assign w_bus_idx     = avs_address[ADDR_W+1:2];
    assign w_unused_addr = ^{avs_address[31:ADDR_W+2], avs_address[1:0]};
    assign w_burst       = clamp_burst(avs_burstcount);
    assign w_req         = avs_read | avs_write;
    assign w_last_beat   = (r_beat == (r_beats - AVL_BCNT_W'(1)));

    // Stall and acceptance decode; write wins when both strobes are high
    always_comb begin
        w_wait   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (WAIT_CYCLES == 0) w_accept = w_req;
                else                  w_wait   = w_req;
            end
            CMD_WAIT: begin
                if (r_wait_cnt == WAIT_LAST) w_accept = w_req;
                else                         w_wait   = 1'b1;
            end
            WRITE:               w_wait = 1'b0;
            READ_LAT, READ_DATA: w_wait = 1'b1;
            default:             w_wait = 1'b0;
        endcase
        w_acc_wr = w_accept & avs_write;
        w_acc_rd = w_accept & avs_read & ~avs_write;
    end

    // RAM port control: each read is issued one cycle before its beat is shown
    always_comb begin
        w_ram_we   = 1'b0;
        w_ram_re   = 1'b0;
        w_ram_addr = r_base + ADDR_W'(r_beat);
        if (w_acc_wr) begin
            w_ram_we   = 1'b1;
            w_ram_addr = w_bus_idx;
        end else if (w_acc_rd && (READ_LATENCY == 1)) begin
            w_ram_re   = 1'b1;
            w_ram_addr = w_bus_idx;
        end else if ((r_state == WRITE) && avs_write) begin
            w_ram_we   = 1'b1;
        end else if ((r_state == READ_LAT) && (r_lat == LAT_LAST)) begin
            w_ram_re   = 1'b1;
            w_ram_addr = r_base;
        end else if ((r_state == READ_DATA) && !w_last_beat) begin
            w_ram_re   = 1'b1;
            w_ram_addr = r_base + ADDR_W'(r_beat + AVL_BCNT_W'(1));
        end
        if (rst) begin
            w_ram_we = 1'b0;
            w_ram_re = 1'b0;
        end
    end

    // Main FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_beats    <= '0;
            r_beat     <= '0;
            r_wait_cnt <= '0;
            r_lat      <= '0;
            r_rdvalid  <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_rdvalid <= w_ram_re;
            r_perr    <= 1'b0;
            case (r_state)
                IDLE, CMD_WAIT: begin
                    if (w_accept) begin
                        r_base     <= w_bus_idx;
                        r_beats    <= w_burst.beats;
                        r_beat     <= '0;
                        r_wait_cnt <= '0;
                        r_perr     <= w_burst.err | (avs_read & avs_write);
                        if (avs_write) begin
                            if (w_burst.beats > AVL_BCNT_W'(1)) begin
                                r_state <= WRITE;
                                r_beat  <= AVL_BCNT_W'(1);
                            end else begin
                                r_state <= IDLE;
                            end
                        end else if (READ_LATENCY == 1) begin
                            r_state <= READ_DATA;
                        end else begin
                            r_state <= READ_LAT;
                            r_lat   <= 4'd1;
                        end
                    end else if (w_wait) begin
                        r_state    <= CMD_WAIT;
                        r_wait_cnt <= r_wait_cnt + 3'd1;
                    end else begin
                        r_state    <= IDLE;
                        r_wait_cnt <= '0;
                    end
                end
                WRITE: begin
                    if (avs_read) r_perr <= 1'b1;
                    if (avs_write) begin
                        if (w_last_beat) r_state <= IDLE;
                        else             r_beat  <= r_beat + AVL_BCNT_W'(1);
                    end
                end
                READ_LAT: begin
                    if (r_lat == LAT_LAST) begin
                        r_state <= READ_DATA;
                        r_beat  <= '0;
                    end else begin
                        r_lat <= r_lat + 4'd1;
                    end
                end
                READ_DATA: begin
                    if (w_last_beat) r_state <= IDLE;
                    else             r_beat  <= r_beat + AVL_BCNT_W'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    avalon_resp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_be    (avs_byteenable),
        .i_wdata (avs_writedata),
        .i_re    (w_ram_re),
        .o_rdata (w_ram_rdata)
    );

    assign avs_waitrequest   = w_wait;
    assign avs_readdatavalid = r_rdvalid;
    assign avs_readdata      = w_ram_rdata;
    assign protocol_error    = r_perr;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Scoreboard bench for avalon_mem_responder. Instance 0 runs with
// READ_LATENCY=1/WAIT_CYCLES=0, instance 1 with READ_LATENCY=3/WAIT_CYCLES=2.
// Read tasks queue expected (data, cycle) pairs; a negedge monitor pops them.
module tb_avalon_mem_responder;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic [2:0]  bc    [2];
    logic        wr    [2];
    logic        rd    [2];
    logic        wait_r[2];
    logic        rdv   [2];
    logic        perr  [2];
    logic [31:0] rdata [2];

    exp_t q0[$];
    exp_t q1[$];
    int   cyc       = 0;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   perr_cnt0 = 0;
    int   perr_cnt1 = 0;
    int   exp_perr0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(1), .WAIT_CYCLES(0)) u_fast (
        .clk(clk), .rst(rst), .avs_address(addr[0]), .avs_writedata(wdata[0]),
        .avs_byteenable(be[0]), .avs_burstcount(bc[0]), .avs_write(wr[0]), .avs_read(rd[0]),
        .avs_waitrequest(wait_r[0]), .avs_readdatavalid(rdv[0]), .avs_readdata(rdata[0]),
        .protocol_error(perr[0]));

    avalon_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(3), .WAIT_CYCLES(2)) u_stall (
        .clk(clk), .rst(rst), .avs_address(addr[1]), .avs_writedata(wdata[1]),
        .avs_byteenable(be[1]), .avs_burstcount(bc[1]), .avs_write(wr[1]), .avs_read(rd[1]),
        .avs_waitrequest(wait_r[1]), .avs_readdatavalid(rdv[1]), .avs_readdata(rdata[1]),
        .protocol_error(perr[1]));

    function automatic int rl_of(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    function automatic int wait_of(input int s);
        return (s == 0) ? 0 : 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_beat(input int s, input logic [31:0] d);
        exp_t e;
        int   sz;
        sz = (s == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rdvalid inst%0d: got data 0x%08h want no beat (cycle %0d)", s, d, cyc);
        end else begin
            e = (s == 0) ? q0.pop_front() : q1.pop_front();
            chk("rd_data", d, e.data);
            chk("rd_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    // Scoreboard monitor, sampling away from the rising edge
    always @(negedge clk) begin
        if (rdv[0] === 1'b1) mon_beat(0, rdata[0]);
        if (rdv[1] === 1'b1) mon_beat(1, rdata[1]);
        if (perr[0] === 1'b1) perr_cnt0++;
        if (perr[1] === 1'b1) perr_cnt1++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input int s, input logic [31:0] a, input logic [2:0] c, input int n,
                            input logic [31:0] d0, input logic [31:0] step, input logic [3:0] m,
                            input int gap_after, input bit both);
        int stall;
        int late;
        @(posedge clk); #1;
        addr[s] = a; bc[s] = c; wdata[s] = d0; be[s] = m; wr[s] = 1'b1; rd[s] = both;
        stall = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!wait_r[s]) break;
            stall++;
        end
        chk("wr_cmd_stall", 32'(stall), 32'(wait_of(s)));
        late = 0;
        for (int k = 1; k < n; k++) begin
            @(posedge clk); #1;
            rd[s] = 1'b0;
            if (k == gap_after + 1) begin
                wr[s] = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
            wr[s] = 1'b1;
            wdata[s] = d0 + step * 32'(k);
            @(negedge clk);
            if (wait_r[s]) late++;
        end
        if (n > 1) chk("wr_beat_stall", 32'(late), 32'(0));
        @(posedge clk); #1;
        wr[s] = 1'b0; rd[s] = 1'b0;
    endtask

    task automatic rd_burst(input int s, input logic [31:0] a, input logic [2:0] c, input int n,
                            input logic [31:0] d0, input logic [31:0] step, input int abort_at);
        int   stall;
        int   t;
        int   fall;
        int   npush;
        exp_t e;
        @(posedge clk); #1;
        addr[s] = a; bc[s] = c; rd[s] = 1'b1;
        stall = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!wait_r[s]) break;
            stall++;
        end
        chk("rd_cmd_stall", 32'(stall), 32'(wait_of(s)));
        t = cyc;
        npush = (abort_at >= 0) ? abort_at : n;
        for (int k = 0; k < npush; k++) begin
            e.data = d0 + step * 32'(k);
            e.cyc  = t + rl_of(s) + k;
            if (s == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk); #1;
        rd[s] = 1'b0;
        if (abort_at >= 0) begin
            while (cyc < t + rl_of(s) + abort_at - 1) begin
                @(posedge clk); #1;
            end
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
        end else begin
            fall = -1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (!wait_r[s]) begin
                    fall = cyc;
                    break;
                end
            end
            chk("rd_wait_fall", 32'(fall), 32'(t + rl_of(s) + n));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            addr[s] = '0; wdata[s] = '0; be[s] = '0; bc[s] = 3'd1; wr[s] = 1'b0; rd[s] = 1'b0;
        end
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_rdvalid", 32'(rdv[s]), 32'(0));
            chk("rst_rdata", rdata[s], 32'h0);
            chk("rst_perr", 32'(perr[s]), 32'(0));
            chk("rst_wait", 32'(wait_r[s]), 32'(0));
        end

        // Line write then line read
        wr_burst(0, 32'h100, 3'd4, 4, 32'h11111111, 32'h11111111, 4'hF, -1, 1'b0);
        rd_burst(0, 32'h100, 3'd4, 4, 32'h11111111, 32'h11111111, -1);

        // Partial write merges upper half-word into preloaded dword
        wr_burst(0, 32'h20, 3'd1, 1, 32'hAABBCCDD, 32'h0, 4'hF, -1, 1'b0);
        wr_burst(0, 32'h22, 3'd1, 1, 32'h12345678, 32'h0, 4'b1100, -1, 1'b0);
        rd_burst(0, 32'h20, 3'd1, 1, 32'h1234CCDD, 32'h0, -1);

        // Gapped write burst
        wr_burst(0, 32'h200, 3'd3, 3, 32'hC0DE0000, 32'h1, 4'hF, 1, 1'b0);
        rd_burst(0, 32'h200, 3'd3, 3, 32'hC0DE0000, 32'h1, -1);

        // Read and write together: write stored, read dropped
        wr_burst(0, 32'h300, 3'd1, 1, 32'hDEADBEEF, 32'h0, 4'hF, -1, 1'b1);
        exp_perr0++;
        idle(2);
        chk("perr_rd_wr", 32'(perr_cnt0), 32'(exp_perr0));
        rd_burst(0, 32'h300, 3'd1, 1, 32'hDEADBEEF, 32'h0, -1);

        // Burstcount 0 becomes a single beat, for both directions
        wr_burst(0, 32'h304, 3'd0, 1, 32'h0BADF00D, 32'h0, 4'hF, -1, 1'b0);
        exp_perr0++;
        rd_burst(0, 32'h304, 3'd0, 1, 32'h0BADF00D, 32'h0, -1);
        exp_perr0++;
        idle(2);
        chk("perr_bc0", 32'(perr_cnt0), 32'(exp_perr0));

        // Burstcount 7 clamps to 4 beats
        rd_burst(0, 32'h100, 3'd7, 4, 32'h11111111, 32'h11111111, -1);
        exp_perr0++;
        idle(2);
        chk("perr_bc7", 32'(perr_cnt0), 32'(exp_perr0));

        // Burst wraps at top of memory; high address bits alias
        wr_burst(0, 32'hFFC, 3'd2, 2, 32'h5A5A0001, 32'h1, 4'hF, -1, 1'b0);
        rd_burst(0, 32'hFFC, 3'd2, 2, 32'h5A5A0001, 32'h1, -1);
        rd_burst(0, 32'h1000, 3'd1, 1, 32'h5A5A0002, 32'h0, -1);

        // Reset after beat 1 of a 4-beat read, then re-read
        rd_burst(0, 32'h100, 3'd4, 4, 32'h11111111, 32'h11111111, 2);
        idle(4);
        chk("rst_mid_q_empty", 32'(q0.size()), 32'(0));
        rd_burst(0, 32'h100, 3'd4, 4, 32'h11111111, 32'h11111111, -1);

        // Code-fetch stall on the slow instance
        wr_burst(1, 32'h8, 3'd4, 4, 32'hA0A0A0A0, 32'h01010101, 4'hF, -1, 1'b0);
        rd_burst(1, 32'h8, 3'd4, 4, 32'hA0A0A0A0, 32'h01010101, -1);

        idle(5);
        chk("final_q0_empty", 32'(q0.size()), 32'(0));
        chk("final_q1_empty", 32'(q1.size()), 32'(0));
        chk("final_perr0", 32'(perr_cnt0), 32'(exp_perr0));
        chk("final_perr1", 32'(perr_cnt1), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
